// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive buffer slice.
package uart_rx_fifo_pkg;

    localparam int NB_DATA_DEFAULT = 8;
    localparam int NB_ADDR_DEFAULT = 4;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Producer/consumer bundle around the UART receive buffer.
// The master side drives the write and pop strobes; the slave side returns status and data.
interface uart_rx_fifo_if
    import uart_rx_fifo_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEFAULT,
    parameter int NB_ADDR = NB_ADDR_DEFAULT
);

    logic               wr;
    logic [NB_DATA-1:0] wr_data;
    logic               rd;
    logic               clr_ovf;
    logic [NB_DATA-1:0] rd_data;
    logic               empty;
    logic               full;
    logic [NB_ADDR:0]   count;
    logic               overflow;

    modport master (
        output wr, wr_data, rd, clr_ovf,
        input  rd_data, empty, full, count, overflow
    );

    modport slave (
        input  wr, wr_data, rd, clr_ovf,
        output rd_data, empty, full, count, overflow
    );

endinterface

// File: rtl/fifo_regfile.sv
// Storage array for the receive buffer: synchronous write, asynchronous read, no reset.
module fifo_regfile #(
    parameter int NB_DATA = 8,
    parameter int NB_ADDR = 4
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** NB_ADDR;

    logic [NB_DATA-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive byte buffer behind the UART receiver, with count/full/empty
// status and a sticky overflow flag for bytes dropped while full.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEFAULT,
    parameter int NB_ADDR = NB_ADDR_DEFAULT
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wr,
    input  logic [NB_DATA-1:0] i_wr_data,
    input  logic               i_rd,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_empty,
    output logic               o_full,
    output logic [NB_ADDR:0]   o_count,
    output logic               o_overflow,
    input  logic               i_clr_ovf
);

    localparam logic [NB_ADDR:0] PTR_ONE = {{NB_ADDR{1'b0}}, 1'b1};

    logic [NB_ADDR:0] wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR:0] rd_ptr_q, rd_ptr_d;
    logic             ovf_q, ovf_d;
    logic             empty, full, we, re, drop;

    // Extra pointer MSB separates full from empty when the address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[NB_ADDR-1:0] == rd_ptr_q[NB_ADDR-1:0]) &&
                   (wr_ptr_q[NB_ADDR] != rd_ptr_q[NB_ADDR]);

    always_comb begin
        we       = i_wr & (~full | i_rd);
        re       = i_rd & ~empty;
        drop     = i_wr & full & ~i_rd;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (we) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (re) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
        end
    end

    fifo_regfile #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_we    (we),
        .i_waddr (wr_ptr_q[NB_ADDR-1:0]),
        .i_wdata (i_wr_data),
        .i_raddr (rd_ptr_q[NB_ADDR-1:0]),
        .o_rdata (o_rd_data)
    );

    assign o_empty    = empty;
    assign o_full     = full;
    assign o_count    = wr_ptr_q - rd_ptr_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized checks of uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int NB_DATA = 8;
    localparam int NB_ADDR = 4;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    logic rst_n;

    uart_rx_fifo_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

    uart_rx_fifo #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_wr       (bus.wr),
        .i_wr_data  (bus.wr_data),
        .i_rd       (bus.rd),
        .o_rd_data  (bus.rd_data),
        .o_empty    (bus.empty),
        .o_full     (bus.full),
        .o_count    (bus.count),
        .o_overflow (bus.overflow),
        .i_clr_ovf  (bus.clr_ovf)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] mq[$];
    logic       ovf_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".empty"}, 32'(bus.empty), 32'(mq.size() == 0));
        check({tag, ".full"}, 32'(bus.full), 32'(mq.size() == DEPTH));
        check({tag, ".count"}, 32'(bus.count), 32'(mq.size()));
        check({tag, ".ovf"}, 32'(bus.overflow), 32'(ovf_m));
        if (mq.size() != 0) begin
            check({tag, ".data"}, 32'(bus.rd_data), 32'(mq[0]));
        end
    endtask

    // Reference behaviour: pop happens if something is stored, push happens
    // if there is room or a pop is freeing a slot in the same cycle.
    task automatic model_update(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (rd && !was_empty) void'(mq.pop_front());
        if (wr && (!was_full || rd)) mq.push_back(d);
        if (clr) ovf_m = 1'b0;
        if (wr && was_full && !rd) ovf_m = 1'b1;
    endtask

    task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr,
                        input string tag);
        bus.wr      = wr;
        bus.wr_data = d;
        bus.rd      = rd;
        bus.clr_ovf = clr;
        @(posedge clk);
        model_update(wr, d, rd, clr);
        #1;
        bus.wr      = 1'b0;
        bus.rd      = 1'b0;
        bus.clr_ovf = 1'b0;
        check_state(tag);
    endtask

    initial begin
        logic [7:0] v;
        int         wr_pct;
        int         rd_pct;

        rst_n       = 1'b0;
        bus.wr      = 1'b0;
        bus.wr_data = '0;
        bus.rd      = 1'b0;
        bus.clr_ovf = 1'b0;
        ovf_m       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset");
        check("reset.count0", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single byte through
        step(1'b1, 8'hA5, 1'b0, 1'b0, "t1_wr");
        check("t1_data", 32'(bus.rd_data), 32'h0000_00A5);
        check("t1_cnt", 32'(bus.count), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t1_rd");
        check("t1_empty", 32'(bus.empty), 32'd1);

        // 2: fill/drain twice so the pointers wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v = 8'(r * 16 + i);
                step(1'b1, v, 1'b0, 1'b0, "t2_fill");
            end
            check("t2_full", 32'(bus.full), 32'd1);
            check("t2_cnt16", 32'(bus.count), 32'd16);
            for (int i = 0; i < DEPTH; i++) begin
                check("t2_order", 32'(bus.rd_data), 32'(r * 16 + i));
                step(1'b0, 8'h00, 1'b1, 1'b0, "t2_drain");
            end
            check("t2_empty", 32'(bus.empty), 32'd1);
        end

        // 3: overflow drop, clear, and set-beats-clear
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'(8'h40 + i);
            step(1'b1, v, 1'b0, 1'b0, "t3_fill");
        end
        step(1'b1, 8'h77, 1'b0, 1'b0, "t3_drop");
        check("t3_ovf_set", 32'(bus.overflow), 32'd1);
        check("t3_head", 32'(bus.rd_data), 32'h0000_0040);
        step(1'b0, 8'h00, 1'b0, 1'b1, "t3_clr");
        check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
        step(1'b1, 8'h77, 1'b0, 1'b1, "t3_both");
        check("t3_set_wins", 32'(bus.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "t3_clr2");

        // 4: write+pop while full keeps count at 16, no overflow
        step(1'b1, 8'h3C, 1'b1, 1'b0, "t4_wrrd");
        check("t4_cnt", 32'(bus.count), 32'd16);
        check("t4_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("t4_last", 32'(bus.rd_data), 32'h0000_003C);
            step(1'b0, 8'h00, 1'b1, 1'b0, "t4_drain");
        end

        // 5: write+pop while empty, then pop on empty
        step(1'b1, 8'h5A, 1'b1, 1'b0, "t5_wrrd");
        check("t5_cnt", 32'(bus.count), 32'd1);
        check("t5_data", 32'(bus.rd_data), 32'h0000_005A);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5_pop");
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5_underflow");
        step(1'b1, 8'h11, 1'b0, 1'b0, "t5_after");
        check("t5_after_data", 32'(bus.rd_data), 32'h0000_0011);
        step(1'b0, 8'h00, 1'b1, 1'b0, "t5_pop2");

        // 6: asynchronous reset between edges
        for (int i = 0; i < 5; i++) begin
            v = 8'(8'h90 + i);
            step(1'b1, v, 1'b0, 1'b0, "t6_load");
        end
        step(1'b1, 8'h00, 1'b0, 1'b0, "t6_more");
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        ovf_m = 1'b0;
        check_state("t6_rst");
        check("t6_cnt0", 32'(bus.count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 8'hC3, 1'b0, 1'b0, "t6_wr");
        check("t6_data", 32'(bus.rd_data), 32'h0000_00C3);

        // Randomized traffic with shifting write/read bias to visit full and empty
        for (int c = 0; c < 800; c++) begin
            case ((c / 100) % 4)
                0: begin wr_pct = 80; rd_pct = 20; end
                1: begin wr_pct = 20; rd_pct = 80; end
                2: begin wr_pct = 50; rd_pct = 50; end
                default: begin wr_pct = 95; rd_pct = 5; end
            endcase
            step(1'($urandom_range(0, 99) < wr_pct), 8'($urandom),
                 1'($urandom_range(0, 99) < rd_pct), 1'($urandom_range(0, 99) < 10),
                 "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
